// File: rtl/local_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : local_packet_scheduler
// Brief    : Round-robin scheduler streaming one requester packet at a time
//            into a packet processor, with an enforced inter-packet gap.
// Revision : 1.0 - initial release
// ============================================================================
module local_packet_scheduler #(
    parameter int GAP_CYCLES = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic         FillClock,
    input  logic         Reset,
    input  logic [3:0]   ReqValid,
    input  logic [3:0]   ReqEnable,
    input  logic [47:0]  ReqSize,
    input  logic [47:0]  ReqDest,
    input  logic [127:0] ReqData,
    input  logic         ProcFull,
    output logic [3:0]   ReqRdEn,
    output logic [3:0]   ReqDone,
    output logic [3:0]   ReqErr,
    output logic [31:0]  PktData,
    output logic         PktDataValid,
    output logic [11:0]  PktSize,
    output logic [11:0]  PktDest,
    output logic         Busy,
    output logic [1:0]   GrantIdx,
    output logic [15:0]  PacketCount,
    output logic [7:0]   ErrCount
);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_GRANT  = 2'd1;
    localparam logic [1:0] c_STREAM = 2'd2;
    localparam logic [1:0] c_GAP    = 2'd3;

    localparam int               c_GAP_W    = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES);
    localparam logic [12:0]      c_MAX_WORDS = 13'(MAX_WORDS);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [1:0]         r_grant;
    logic [1:0]         r_rr_start;
    logic [11:0]        r_words;
    logic [c_GAP_W-1:0] r_gap;
    logic [15:0]        r_pkt_count;
    logic [7:0]         r_err_count;
    logic [31:0]        r_pkt_data;
    logic               r_pkt_valid;
    logic [11:0]        r_pkt_size;
    logic [11:0]        r_pkt_dest;
    logic [3:0]         r_done;

    logic [3:0]         w_req;
    logic [1:0]         w_sel_idx;
    logic               w_sel_found;
    logic               w_start;
    logic               w_illegal;
    logic               w_rd;
    logic [3:0]         w_grant_oh;
    logic [11:0]        w_size_arr [4];
    logic [11:0]        w_dest_arr [4];
    logic [31:0]        w_data_arr [4];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_unpack
            assign w_size_arr[i] = ReqSize[12*i +: 12];
            assign w_dest_arr[i] = ReqDest[12*i +: 12];
            assign w_data_arr[i] = ReqData[32*i +: 32];
        end
    endgenerate

    assign w_req      = ReqValid & ReqEnable;
    assign w_grant_oh = 4'b0001 << r_grant;
    assign w_illegal  = (r_words == 12'd0) || ({1'b0, r_words} > c_MAX_WORDS);
    assign w_rd       = (r_state == c_STREAM) && (r_words != 12'd0);
    assign w_start    = (r_state == c_IDLE) && w_sel_found && !ProcFull && (r_gap == '0);

    // First eligible requester at or after the round-robin start index
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = r_rr_start;
        for (int k = 0; k < 4; k++) begin
            if (!w_sel_found && w_req[r_rr_start + 2'(k)]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = r_rr_start + 2'(k);
            end
        end
    end

    always_ff @(posedge FillClock) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (w_start) w_next_state = c_GRANT;
            c_GRANT:  w_next_state = w_illegal ? c_IDLE : c_STREAM;
            c_STREAM: if (r_words == 12'd0) w_next_state = c_GAP;
            c_GAP:    if (r_gap <= c_GAP_W'(1)) w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        Busy    = (r_state != c_IDLE);
        ReqRdEn = w_rd ? w_grant_oh : 4'b0000;
        ReqErr  = ((r_state == c_GRANT) && w_illegal) ? w_grant_oh : 4'b0000;
    end

    // Streaming counts r_words down to 0; the extra STREAM cycle at 0 drains
    // the last registered word before ReqDone fires in the first GAP cycle.
    always_ff @(posedge FillClock) begin
        if (Reset) begin
            r_grant     <= 2'd0;
            r_rr_start  <= 2'd0;
            r_words     <= 12'd0;
            r_gap       <= '0;
            r_pkt_count <= 16'd0;
            r_err_count <= 8'd0;
            r_pkt_data  <= 32'd0;
            r_pkt_valid <= 1'b0;
            r_pkt_size  <= 12'd0;
            r_pkt_dest  <= 12'd0;
            r_done      <= 4'b0000;
        end else begin
            r_done      <= 4'b0000;
            r_pkt_valid <= w_rd;
            if (w_rd) begin
                r_pkt_data <= w_data_arr[r_grant];
            end
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_grant    <= w_sel_idx;
                        r_rr_start <= w_sel_idx + 2'd1;
                        r_pkt_size <= w_size_arr[w_sel_idx];
                        r_pkt_dest <= w_dest_arr[w_sel_idx];
                        r_words    <= w_size_arr[w_sel_idx];
                    end
                end
                c_GRANT: begin
                    if (w_illegal && (r_err_count != 8'hFF)) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                c_STREAM: begin
                    if (r_words != 12'd0) begin
                        r_words <= r_words - 12'd1;
                    end else begin
                        r_done      <= w_grant_oh;
                        r_pkt_count <= r_pkt_count + 16'd1;
                        r_gap       <= c_GAP_LOAD;
                    end
                end
                default: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - c_GAP_W'(1);
                    end
                end
            endcase
        end
    end

    assign ReqDone      = r_done;
    assign PktData      = r_pkt_data;
    assign PktDataValid = r_pkt_valid;
    assign PktSize      = r_pkt_size;
    assign PktDest      = r_pkt_dest;
    assign GrantIdx     = r_grant;
    assign PacketCount  = r_pkt_count;
    assign ErrCount     = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_local_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_local_packet_scheduler
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_local_packet_scheduler;
    localparam int c_GAP = 8;
    localparam int c_MAX = 256;

    logic         FillClock = 1'b0;
    logic         Reset;
    logic [3:0]   ReqValid;
    logic [3:0]   ReqEnable;
    logic [47:0]  ReqSize;
    logic [47:0]  ReqDest;
    logic [127:0] ReqData;
    logic         ProcFull;
    logic [3:0]   ReqRdEn;
    logic [3:0]   ReqDone;
    logic [3:0]   ReqErr;
    logic [31:0]  PktData;
    logic         PktDataValid;
    logic [11:0]  PktSize;
    logic [11:0]  PktDest;
    logic         Busy;
    logic [1:0]   GrantIdx;
    logic [15:0]  PacketCount;
    logic [7:0]   ErrCount;

    logic [11:0]  sz [4];
    logic [11:0]  ds [4];
    int           pop_cnt [4] = '{0, 0, 0, 0};
    int           checks   = 0;
    int           failures = 0;
    int           exp_pkts = 0;
    int           exp_errs = 0;

    typedef struct {
        int          idx;
        logic [11:0] size;
        logic [11:0] dest;
        bit          pf_mid;
        bit          exp_err;
    } vec_t;

    local_packet_scheduler #(.GAP_CYCLES(c_GAP), .MAX_WORDS(c_MAX)) u_dut (
        .FillClock    (FillClock),
        .Reset        (Reset),
        .ReqValid     (ReqValid),
        .ReqEnable    (ReqEnable),
        .ReqSize      (ReqSize),
        .ReqDest      (ReqDest),
        .ReqData      (ReqData),
        .ProcFull     (ProcFull),
        .ReqRdEn      (ReqRdEn),
        .ReqDone      (ReqDone),
        .ReqErr       (ReqErr),
        .PktData      (PktData),
        .PktDataValid (PktDataValid),
        .PktSize      (PktSize),
        .PktDest      (PktDest),
        .Busy         (Busy),
        .GrantIdx     (GrantIdx),
        .PacketCount  (PacketCount),
        .ErrCount     (ErrCount)
    );

    always #5 FillClock = ~FillClock;

    function automatic logic [31:0] wdata(input int i, input int k);
        return (32'(i) << 28) | 32'(k + 1);
    endfunction

    // Each requester behaves as a FWFT FIFO: a pop advances its head word
    always @(posedge FillClock) begin
        for (int i = 0; i < 4; i++) begin
            if (ReqRdEn[i]) pop_cnt[i] <= pop_cnt[i] + 1;
        end
    end

    assign ReqData = {wdata(3, pop_cnt[3]), wdata(2, pop_cnt[2]), wdata(1, pop_cnt[1]), wdata(0, pop_cnt[0])};
    assign ReqSize = {sz[3], sz[2], sz[1], sz[0]};
    assign ReqDest = {ds[3], ds[2], ds[1], ds[0]};

    task automatic tick();
        @(negedge FillClock);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int start);
        for (int k = 0; k < 4; k++) begin
            if (req[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic do_reset();
        Reset = 1'b1; ReqValid = 4'b0; ProcFull = 1'b0; ReqEnable = 4'hF;
        tick(); tick();
        Reset = 1'b0;
        exp_pkts = 0; exp_errs = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rden"},  ReqRdEn, 0);
        check({tag, "_done"},  ReqDone, 0);
        check({tag, "_err"},   ReqErr, 0);
        check({tag, "_data"},  PktData, 0);
        check({tag, "_valid"}, PktDataValid, 0);
        check({tag, "_size"},  PktSize, 0);
        check({tag, "_dest"},  PktDest, 0);
        check({tag, "_busy"},  Busy, 0);
        check({tag, "_gidx"},  GrantIdx, 0);
        check({tag, "_pcnt"},  PacketCount, 0);
        check({tag, "_ecnt"},  ErrCount, 0);
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 400 && Busy; t++) tick();
        check("idle_timeout", Busy, 0);
    endtask

    task automatic wait_done(input int idx);
        int t;
        bit seen;
        seen = 1'b0;
        for (t = 0; t < 400 && !seen; t++) begin
            tick();
            if (ReqDone[idx]) seen = 1'b1;
        end
        check("done_timeout", seen, 1);
        ReqValid = 4'b0;
        wait_idle();
    endtask

    task automatic run_pkt(input vec_t v);
        int base, nvalid, first_v, dones, errs, gapc, t;
        bit seen_grant, finished;
        base = pop_cnt[v.idx];
        sz[v.idx] = v.size;
        ds[v.idx] = v.dest;
        ReqValid = 4'(1 << v.idx);
        nvalid = 0; first_v = -1; dones = 0; errs = 0;
        seen_grant = 1'b0; finished = 1'b0;
        for (t = 1; t <= 400 && !finished; t++) begin
            tick();
            if (Busy && !seen_grant) begin
                seen_grant = 1'b1;
                check("vec_grant_idx", GrantIdx, v.idx);
                check("vec_pkt_size", PktSize, v.size);
                check("vec_pkt_dest", PktDest, v.dest);
            end
            if (PktDataValid) begin
                if (first_v < 0) first_v = t;
                check("vec_pkt_data", PktData, wdata(v.idx, base + nvalid));
                nvalid++;
                if (v.pf_mid) ProcFull = 1'b1;
            end
            if (ReqErr != 4'b0) begin
                errs++;
                check("vec_err_onehot", ReqErr, 1 << v.idx);
                finished = 1'b1;
            end
            if (ReqDone != 4'b0) begin
                dones++;
                check("vec_done_onehot", ReqDone, 1 << v.idx);
                finished = 1'b1;
            end
        end
        ReqValid = 4'b0;
        check("vec_finished", finished, 1);
        if (v.exp_err) exp_errs++; else exp_pkts++;
        check("vec_done_pulses", dones, v.exp_err ? 0 : 1);
        check("vec_err_pulses", errs, v.exp_err ? 1 : 0);
        check("vec_word_count", nvalid, v.exp_err ? 0 : int'(v.size));
        if (!v.exp_err) begin
            check("vec_latency", first_v, 3);
            gapc = 1;
            for (t = 0; t < 40 && Busy; t++) begin
                tick();
                if (Busy) gapc++;
            end
            check("vec_gap_len", gapc, c_GAP);
        end else begin
            tick();
        end
        check("vec_pkt_count", PacketCount, exp_pkts);
        check("vec_err_count", ErrCount, exp_errs);
        ProcFull = 1'b0;
        wait_idle();
    endtask

    vec_t vecs [7];
    int   rr_exp [5];
    int   dcnt [4];
    int   m_word [4];
    int   ngr, ndone, nv, g, cur, cnt, last_v, m_ptr, m_pkts, m_errs, r;
    bit   prev_busy, prev_pf, first_pending;
    logic [3:0] prev_req;

    initial begin
        vecs[0] = '{idx: 0, size: 12'd4,   dest: 12'h123, pf_mid: 1'b0, exp_err: 1'b0};
        vecs[1] = '{idx: 2, size: 12'd0,   dest: 12'h0AA, pf_mid: 1'b0, exp_err: 1'b1};
        vecs[2] = '{idx: 2, size: 12'd300, dest: 12'h0BB, pf_mid: 1'b0, exp_err: 1'b1};
        vecs[3] = '{idx: 1, size: 12'd256, dest: 12'h456, pf_mid: 1'b0, exp_err: 1'b0};
        vecs[4] = '{idx: 3, size: 12'd1,   dest: 12'hFFF, pf_mid: 1'b0, exp_err: 1'b0};
        vecs[5] = '{idx: 2, size: 12'd257, dest: 12'h001, pf_mid: 1'b0, exp_err: 1'b1};
        vecs[6] = '{idx: 0, size: 12'd5,   dest: 12'h777, pf_mid: 1'b1, exp_err: 1'b0};
        rr_exp  = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin sz[i] = 12'd0; ds[i] = 12'd0; end

        do_reset();
        check_zero("reset");

        for (int i = 0; i < 7; i++) run_pkt(vecs[i]);

        // ProcFull only holds off the start
        ProcFull = 1'b1; sz[0] = 12'd2; ReqValid = 4'b0001;
        for (int i = 0; i < 5; i++) begin tick(); check("bp_hold_busy", Busy, 0); end
        ProcFull = 1'b0;
        tick();
        check("bp_release_busy", Busy, 1);
        check("bp_release_gidx", GrantIdx, 0);
        wait_done(0);

        // Masked requester is never granted
        ReqEnable = 4'b1101; sz[1] = 12'd2; ReqValid = 4'b0010;
        for (int i = 0; i < 5; i++) begin tick(); check("mask_hold_busy", Busy, 0); end
        ReqEnable = 4'hF;
        tick();
        check("mask_release_busy", Busy, 1);
        check("mask_release_gidx", GrantIdx, 1);
        wait_done(1);

        // Round robin with all requesters held
        do_reset();
        for (int i = 0; i < 4; i++) begin sz[i] = 12'd2; dcnt[i] = 0; end
        ReqValid = 4'hF; ngr = 0; ndone = 0; prev_busy = 1'b0;
        for (int t = 0; t < 300 && ndone < 5; t++) begin
            tick();
            if (Busy && !prev_busy) begin
                if (ngr < 5) check("rr_grant", GrantIdx, rr_exp[ngr]);
                ngr++;
            end
            for (int i = 0; i < 4; i++) begin
                if (ReqDone[i]) begin dcnt[i]++; ndone++; end
            end
            prev_busy = Busy;
        end
        ReqValid = 4'b0;
        check("rr_ndone", ndone, 5);
        check("rr_done0", dcnt[0], 2);
        check("rr_done1", dcnt[1], 1);
        check("rr_done2", dcnt[2], 1);
        check("rr_done3", dcnt[3], 1);
        check("rr_pkt_count", PacketCount, 5);
        wait_idle();

        // Reset while word 3 of 8 is being popped
        sz[1] = 12'd8; ds[1] = 12'h3C3; ReqValid = 4'b0010; nv = 0;
        for (int t = 0; t < 40 && nv < 2; t++) begin
            tick();
            if (PktDataValid) nv++;
        end
        check("rst_mid_rden", ReqRdEn, 4'b0010);
        Reset = 1'b1; ReqValid = 4'b0;
        tick();
        check_zero("rst_mid");
        Reset = 1'b0;
        tick();
        check("rst_mid_nodone", ReqDone, 0);
        check("rst_mid_pcnt", PacketCount, 0);
        for (int i = 0; i < 4; i++) sz[i] = 12'd1;
        ReqValid = 4'hF;
        tick();
        check("rst_mid_regrant_busy", Busy, 1);
        check("rst_mid_regrant_gidx", GrantIdx, 0);
        ReqValid = 4'b0001;
        wait_done(0);

        // Randomized traffic against the transaction-level model
        do_reset();
        for (int i = 0; i < 4; i++) m_word[i] = pop_cnt[i];
        m_ptr = 0; m_pkts = 0; m_errs = 0; cur = 0; cnt = 0; last_v = -100;
        prev_busy = 1'b0; prev_req = 4'b0; prev_pf = 1'b0; first_pending = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!prev_busy) check("rnd_start", Busy, int'(prev_req != 4'b0 && !prev_pf));
            if (!prev_busy && Busy) begin
                g = rr_pick(prev_req, m_ptr);
                if (g < 0) g = 0;
                check("rnd_grant_idx", GrantIdx, g);
                check("rnd_pkt_size", PktSize, sz[g]);
                check("rnd_pkt_dest", PktDest, ds[g]);
                check("rnd_err_count", ErrCount, m_errs);
                m_ptr = (g + 1) % 4; cur = g; cnt = 0; first_pending = 1'b1;
                if (sz[g] == 12'd0 || int'(sz[g]) > c_MAX) begin
                    check("rnd_err", ReqErr, 1 << g);
                    if (m_errs < 255) m_errs++;
                end else begin
                    check("rnd_noerr", ReqErr, 0);
                end
            end
            if (PktDataValid) begin
                if (first_pending) begin
                    check("rnd_gap", int'(c - last_v > c_GAP), 1);
                    first_pending = 1'b0;
                end
                check("rnd_data", PktData, wdata(cur, m_word[cur]));
                m_word[cur]++; cnt++; last_v = c;
            end
            if (ReqDone != 4'b0) begin
                check("rnd_done", ReqDone, 1 << cur);
                check("rnd_len", cnt, sz[cur]);
                m_pkts++;
                check("rnd_pkt_count", PacketCount, m_pkts & 16'hFFFF);
            end
            for (int i = 0; i < 4; i++) begin
                if (ReqDone[i] || ReqErr[i]) begin
                    ReqValid[i] = 1'b0;
                end else if (!ReqValid[i] && c < 2500 && $urandom_range(0, 7) == 0) begin
                    r = $urandom_range(0, 15);
                    if (r == 0)      sz[i] = 12'd0;
                    else if (r == 1) sz[i] = 12'(257 + $urandom_range(0, 40));
                    else             sz[i] = 12'($urandom_range(1, 6));
                    ds[i] = 12'($urandom_range(0, 4095));
                    ReqValid[i] = 1'b1;
                end
            end
            ProcFull  = (c < 2500) && ($urandom_range(0, 3) == 0);
            ReqEnable = (c < 2500 && $urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            prev_busy = Busy;
            prev_req  = ReqValid & ReqEnable;
            prev_pf   = ProcFull;
        end
        check("rnd_final_pkts", PacketCount, m_pkts & 16'hFFFF);
        check("rnd_final_errs", ErrCount, m_errs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
